sme_param: RTL and testbench
============================

Name: sme_param

Overview:
- Parametrised string-matching engine, next generation of the single-wildcard matcher.
- Buffers one string and one pattern streamed on a shared character bus, then searches the string for the leftmost occurrence of the pattern.
- Pattern syntax: literals, '.', '^', '$' and one optional '*'.
- Sits behind the character-stream front end; the result is reported with a single-cycle valid pulse.

Parameters:
- CHAR_W, 8: character width in bits.
- STR_DEPTH, 32: maximum stored string length (power of 2).
- PAT_DEPTH, 8: maximum stored pattern length.
- IDX_W, $clog2(STR_DEPTH): width of match_index.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset. One clock domain only.
- chardata, input, CHAR_W: character for string or pattern load.
- isstring, input, 1: chardata is a string character this cycle.
- ispattern, input, 1: chardata is a pattern character this cycle.
- valid, output, 1: one-cycle result strobe.
- match, output, 1: pattern found; qualified by valid.
- match_index, output, IDX_W: string index of the first matched character; qualified by valid.

Behaviour:
- Reset values: valid=0, match=0, match_index=0. Reset also clears both buffers, both lengths and the FSM to IDLE.
- Reset mid-LOAD or mid-SEARCH aborts the operation; no valid is issued for it.
- FSM states: IDLE, LOAD_S, LOAD_P, SEARCH, REPORT.
- From IDLE or REPORT:
  - isstring goes to LOAD_S; slen is cleared and chardata is written to slot 0 in that same cycle.
  - ispattern goes to LOAD_P; plen is cleared the same way.
- LOAD_S: each cycle with isstring=1 appends one character. When isstring drops, go to LOAD_P (ispattern is guaranteed the next cycle).
- LOAD_P: each cycle with ispattern=1 appends one character. When ispattern drops, go to SEARCH.
- A pattern without a preceding string reuses the previously stored string.
- Overflow: characters beyond STR_DEPTH or PAT_DEPTH are dropped; the length saturates.
- isstring and ispattern are never asserted together. Either one asserted in SEARCH is a protocol violation and is ignored.
- Token semantics:
  - '.' (0x2E) matches any single character.
  - '^' (0x5E) matches at index 0, or immediately after a space (0x20); it consumes no string character.
  - '$' (0x24) matches at end of string, or immediately before a space; it consumes no character.
  - Anything else is a literal compare on all CHAR_W bits.
- Search order: start positions are tried from 0 to slen-1 in order; the first success wins.
- Per start position, the pattern pointer advances one token per cycle. On a mismatch, restart at start+1 with pattern pointer 0.
- Search completes on the first full-pattern success, or when the start position reaches slen (a start at slen is tried only if the pattern begins with '$').
- match_index is the string position of the first consuming token. For anchor-only patterns it is the position where the anchors held, saturated to STR_DEPTH-1. On no match it is 0.
- Latency: REPORT is entered at most slen*(plen+1)+2 cycles after ispattern falls.
- valid=1 for exactly one cycle in REPORT; match and match_index are updated in the same cycle and held until the next REPORT.
- Back-to-back: isstring or ispattern may assert in the cycle after the valid pulse.

Optional Feature:
- Macro SME_STAR_EN.
- Defined: '*' (0x2A), at most one per pattern, matches zero or more arbitrary characters.
  - The search keeps a resume point: on a mismatch after '*', pattern restarts at token after '*' and string resumes at resume point+1.
  - Leftmost start, shortest star expansion wins.
  - Latency bound becomes slen*slen*(plen+1)+2.
- Undefined: 0x2A is an ordinary literal; no resume-point registers are synthesised.

Decomposition:
- Package sme_pkg holds:
  - Token constants: TOK_ANY=0x2E, TOK_STAR=0x2A, TOK_BOL=0x5E, TOK_EOL=0x24, CH_SPACE=0x20.
  - The FSM state enum.
- One sub-module, sme_tok_cmp: combinational compare of one pattern token against the string character at idx, idx-1 and idx+1 (needed for anchor and space checks) plus slen. Outputs hit and consume.

Test Plan:
- String "hello world", pattern "wor" -> valid once, match=1, match_index=6.
- Same string, pattern "^w.r" with no reload -> match=1, index=6. Then pattern "lo$" -> match=0, index=0.
- String "abc", pattern "c$" -> match=1, index=2. Pattern "xyz" -> match=0, index=0.
- Under SME_STAR_EN: string "abcdef", pattern "b*e" -> match=1, index=1. Without the macro, the same stimulus gives match=0.
- 40-character string (STR_DEPTH=32), pattern matching character 35 -> match=0. Pattern matching character 31 -> index=31.
- Reset asserted 3 cycles into SEARCH -> no valid; outputs are 0; the next load/search completes normally.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared token constants and FSM state encoding for the sme_param string matcher.
package sme_pkg;

  localparam logic [7:0] TOK_ANY  = 8'h2E;
  localparam logic [7:0] TOK_STAR = 8'h2A;
  localparam logic [7:0] TOK_BOL  = 8'h5E;
  localparam logic [7:0] TOK_EOL  = 8'h24;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_S,
    LOAD_P,
    SEARCH,
    REPORT
  } state_t;

endpackage

// File: rtl/sme_tok_cmp.sv
// Compares one pattern token against the string around idx.
// hit: token holds at idx. consume: token advances the string pointer when it hits.
module sme_tok_cmp
  import sme_pkg::*;
#(
  parameter int unsigned CHAR_W = 8,
  parameter int unsigned SL_W   = 6
) (
  input  logic [CHAR_W-1:0] tok,
  input  logic [CHAR_W-1:0] ch_prev,
  input  logic [CHAR_W-1:0] ch_cur,
  input  logic [CHAR_W-1:0] ch_next,
  input  logic [SL_W-1:0]   idx,
  input  logic [SL_W-1:0]   slen,
  output logic              hit,
  output logic              consume
);

  logic cur_ok;
  logic prev_ok;
  logic next_ok;

  // Neighbour characters are only meaningful inside the stored string.
  assign cur_ok  = (idx < slen);
  assign prev_ok = (idx != '0) && (idx <= slen);
  assign next_ok = ({1'b0, idx} + (SL_W + 1)'(1)) < {1'b0, slen};

  always_comb begin
    hit     = 1'b0;
    consume = 1'b0;
    if (tok == CHAR_W'(TOK_BOL)) begin
      hit = (idx == '0) || (prev_ok && (ch_prev == CHAR_W'(CH_SPACE)));
    end else if (tok == CHAR_W'(TOK_EOL)) begin
      hit = (idx == slen) || (next_ok && (ch_next == CHAR_W'(CH_SPACE)));
    end else if (tok == CHAR_W'(TOK_ANY)) begin
      hit     = cur_ok;
      consume = 1'b1;
    end else begin
      hit     = cur_ok && (ch_cur == tok);
      consume = 1'b1;
    end
  end

endmodule

// File: rtl/sme_param.sv
// String-matching engine: buffers a string and a pattern, then reports the leftmost match.
// Optional '*' wildcard support is enabled by defining SME_STAR_EN.
module sme_param
  import sme_pkg::*;
#(
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned STR_DEPTH = 32,
  parameter int unsigned PAT_DEPTH = 8,
  parameter int unsigned IDX_W     = $clog2(STR_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index
);

  localparam int unsigned SL_W = $clog2(STR_DEPTH) + 1;
  localparam int unsigned PL_W = $clog2(PAT_DEPTH) + 1;
  localparam int unsigned PI_W = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;

  state_t state, state_nxt;

  logic [CHAR_W-1:0] str_mem [STR_DEPTH];
  logic [CHAR_W-1:0] pat_mem [PAT_DEPTH];
  logic [SL_W-1:0]   slen;
  logic [PL_W-1:0]   plen;

  logic [SL_W-1:0]   start;
  logic [SL_W-1:0]   sidx;
  logic [PL_W-1:0]   pidx;
  logic              first_set;
  logic [IDX_W-1:0]  first_pos;

  logic [CHAR_W-1:0] tok_c;
  logic              hit_c;
  logic              consume_c;
  logic              pat_done_c;
  logic              begins_eol_c;
  logic              out_of_starts_c;
  logic [IDX_W-1:0]  sat_idx_c;

`ifdef SME_STAR_EN
  logic [SL_W-1:0]   rp;
  logic [PL_W-1:0]   star_pidx;
  logic              star_active;
  logic              first_set_s;
  logic [IDX_W-1:0]  first_pos_s;
  logic              is_star_c;

  assign is_star_c = (tok_c == CHAR_W'(TOK_STAR));
`endif

  assign tok_c        = pat_mem[PI_W'(pidx)];
  assign pat_done_c   = (pidx == plen);
  assign begins_eol_c = (plen != '0) && (pat_mem[0] == CHAR_W'(TOK_EOL));
  // A start at slen is only worth trying when the pattern opens with '$'.
  assign out_of_starts_c = (start > slen) || ((start == slen) && !begins_eol_c);
  assign sat_idx_c = (sidx >= SL_W'(STR_DEPTH)) ? IDX_W'(STR_DEPTH - 1) : IDX_W'(sidx);

  sme_tok_cmp #(
    .CHAR_W (CHAR_W),
    .SL_W   (SL_W)
  ) u_tok_cmp (
    .tok     (tok_c),
    .ch_prev (str_mem[IDX_W'(sidx - SL_W'(1))]),
    .ch_cur  (str_mem[IDX_W'(sidx)]),
    .ch_next (str_mem[IDX_W'(sidx + SL_W'(1))]),
    .idx     (sidx),
    .slen    (slen),
    .hit     (hit_c),
    .consume (consume_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, REPORT: begin
        if (isstring)       state_nxt = LOAD_S;
        else if (ispattern) state_nxt = LOAD_P;
        else                state_nxt = IDLE;
      end
      LOAD_S:  if (!isstring)  state_nxt = LOAD_P;
      LOAD_P:  if (!ispattern) state_nxt = SEARCH;
      SEARCH:  if (pat_done_c || out_of_starts_c) state_nxt = REPORT;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer loading; lengths saturate and excess characters are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      str_mem <= '{default: '0};
      pat_mem <= '{default: '0};
      slen    <= '0;
      plen    <= '0;
    end else begin
      case (state)
        IDLE, REPORT: begin
          if (isstring) begin
            str_mem[0] <= chardata;
            slen       <= SL_W'(1);
          end else if (ispattern) begin
            pat_mem[0] <= chardata;
            plen       <= PL_W'(1);
          end
        end
        LOAD_S: begin
          if (isstring) begin
            if (slen < SL_W'(STR_DEPTH)) begin
              str_mem[IDX_W'(slen)] <= chardata;
              slen                  <= slen + SL_W'(1);
            end
          end else begin
            plen <= ispattern ? PL_W'(1) : '0;
            if (ispattern) pat_mem[0] <= chardata;
          end
        end
        LOAD_P: begin
          if (ispattern && (plen < PL_W'(PAT_DEPTH))) begin
            pat_mem[PI_W'(plen)] <= chardata;
            plen                 <= plen + PL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Search walk: one pattern token per cycle, restart at start+1 on a mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      start       <= '0;
      sidx        <= '0;
      pidx        <= '0;
      first_set   <= 1'b0;
      first_pos   <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
`ifdef SME_STAR_EN
      rp          <= '0;
      star_pidx   <= '0;
      star_active <= 1'b0;
      first_set_s <= 1'b0;
      first_pos_s <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if ((state == LOAD_P) && !ispattern) begin
        start     <= '0;
        sidx      <= '0;
        pidx      <= '0;
        first_set <= 1'b0;
`ifdef SME_STAR_EN
        star_active <= 1'b0;
`endif
      end else if (state == SEARCH) begin
        if (pat_done_c) begin
          valid       <= 1'b1;
          match       <= 1'b1;
          match_index <= first_set ? first_pos : sat_idx_c;
        end else if (out_of_starts_c) begin
          valid       <= 1'b1;
          match       <= 1'b0;
          match_index <= '0;
`ifdef SME_STAR_EN
        end else if (is_star_c && !star_active) begin
          // Zero-length expansion first; rp marks where the star last stopped.
          star_active <= 1'b1;
          star_pidx   <= pidx + PL_W'(1);
          rp          <= sidx;
          first_set_s <= first_set;
          first_pos_s <= first_pos;
          pidx        <= pidx + PL_W'(1);
`endif
        end else if (hit_c) begin
          if (consume_c && !first_set) begin
            first_set <= 1'b1;
            first_pos <= IDX_W'(sidx);
          end
          sidx <= sidx + SL_W'(consume_c);
          pidx <= pidx + PL_W'(1);
`ifdef SME_STAR_EN
        end else if (star_active && (rp < slen)) begin
          rp        <= rp + SL_W'(1);
          sidx      <= rp + SL_W'(1);
          pidx      <= star_pidx;
          first_set <= first_set_s;
          first_pos <= first_pos_s;
`endif
        end else begin
          start     <= start + SL_W'(1);
          sidx      <= start + SL_W'(1);
          pidx      <= '0;
          first_set <= 1'b0;
`ifdef SME_STAR_EN
          star_active <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sme_param.sv
// Self-checking bench for sme_param: directed scenarios plus randomized strings/patterns
// compared against a leftmost-match reference model.
module tb_sme_param;

  localparam int CHAR_W    = 8;
  localparam int STR_DEPTH = 32;
  localparam int PAT_DEPTH = 8;
  localparam int IDX_W     = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [CHAR_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              valid;
  logic              match;
  logic [IDX_W-1:0]  match_index;

  int    checks   = 0;
  int    failures = 0;
  string model_str = "";

  int obs_cyc;
  bit obs_valid;
  bit obs_match;
  int obs_idx;
  bit obs_tail;
  bit obs_held;

  sme_param #(
    .CHAR_W    (CHAR_W),
    .STR_DEPTH (STR_DEPTH),
    .PAT_DEPTH (PAT_DEPTH),
    .IDX_W     (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit p, input logic [7:0] c);
    isstring  = s;
    ispattern = p;
    chardata  = c;
    tick();
  endtask

  // Streams a string (may be empty) followed immediately by a pattern.
  task automatic load(input string s, input string p);
    for (int i = 0; i < s.len(); i++) drive(1'b1, 1'b0, s[i]);
    for (int i = 0; i < p.len(); i++) drive(1'b0, 1'b1, p[i]);
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = '0;
    if (s.len() > 0) model_str = (s.len() > STR_DEPTH) ? s.substr(0, STR_DEPTH - 1) : s;
  endtask

  // Waits (bounded) for the result strobe; optionally samples the following cycle.
  task automatic run(input bit tail);
    obs_valid = 1'b0;
    obs_cyc   = 0;
    obs_tail  = 1'b0;
    obs_held  = 1'b1;
    for (int c = 1; c <= 4000 && !obs_valid; c++) begin
      tick();
      if (valid === 1'b1) begin
        obs_valid = 1'b1;
        obs_cyc   = c;
        obs_match = match;
        obs_idx   = int'(match_index);
      end
    end
    if (obs_valid && tail) begin
      tick();
      obs_tail = (valid !== 1'b0);
      obs_held = (match === obs_match) && (int'(match_index) == obs_idx);
    end
  endtask

  // Leftmost-start search over the spec's token rules (no '*').
  function automatic void ref_search(input string s, input string p, output bit m, output int idx);
    int  n, k, i, first;
    bit  ok;
    byte c;
    n = s.len();
    k = (p.len() > PAT_DEPTH) ? PAT_DEPTH : p.len();
    m = 1'b0;
    idx = 0;
    for (int st = 0; st <= n; st++) begin
      if (st == n && !(k > 0 && p[0] == 8'h24)) break;
      i = st;
      first = -1;
      ok = 1'b1;
      for (int t = 0; t < k && ok; t++) begin
        c = p[t];
        if (c == 8'h5E)      ok = (i == 0) || (i <= n && s[i-1] == 8'h20);
        else if (c == 8'h24) ok = (i == n) || (i + 1 < n && s[i+1] == 8'h20);
        else begin
          ok = (i < n) && (c == 8'h2E || s[i] == c);
          if (ok) begin
            if (first < 0) first = i;
            i++;
          end
        end
      end
      if (ok) begin
        m = 1'b1;
        idx = (first >= 0) ? first : ((i > STR_DEPTH - 1) ? STR_DEPTH - 1 : i);
        return;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; isstring = 1'b0; ispattern = 1'b0; chardata = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (valid !== 1'b0 || match !== 1'b0 || match_index !== '0) begin
      failures++;
      $display("FAIL reset_values: valid=%b match=%b idx=%0d, want 0 0 0", valid, match, match_index);
    end
    tick(); tick();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_valid: valid=%b, want 0", valid);
    end
  endtask

  task automatic test_hello();
    load("hello world", "wor");
    run(1'b1);
    checks++;
    if (!obs_valid || obs_match !== 1'b1 || obs_idx != 6) begin
      failures++;
      $display("FAIL hello_wor: valid=%b match=%b idx=%0d, want 1 1 6", obs_valid, obs_match, obs_idx);
    end
    checks++;
    if (obs_tail || !obs_held) begin
      failures++;
      $display("FAIL pulse_width: extra_valid=%b held=%b, want 0 1", obs_tail, obs_held);
    end
    load("", "^w.r");
    run(1'b0);
    checks++;
    if (!obs_valid || obs_match !== 1'b1 || obs_idx != 6) begin
      failures++;
      $display("FAIL reuse_bol: valid=%b match=%b idx=%0d, want 1 1 6", obs_valid, obs_match, obs_idx);
    end
    tick();
    load("", "lo$");
    run(1'b0);
    checks++;
    if (!obs_valid || obs_match !== 1'b0 || obs_idx != 0) begin
      failures++;
      $display("FAIL reuse_eol: valid=%b match=%b idx=%0d, want 1 0 0", obs_valid, obs_match, obs_idx);
    end
    tick();
  endtask

  task automatic test_abc();
    load("abc", "c$");
    run(1'b1);
    checks++;
    if (!obs_valid || obs_match !== 1'b1 || obs_idx != 2) begin
      failures++;
      $display("FAIL abc_eol: valid=%b match=%b idx=%0d, want 1 1 2", obs_valid, obs_match, obs_idx);
    end
    load("", "xyz");
    run(1'b1);
    checks++;
    if (!obs_valid || obs_match !== 1'b0 || obs_idx != 0) begin
      failures++;
      $display("FAIL abc_nomatch: valid=%b match=%b idx=%0d, want 1 0 0", obs_valid, obs_match, obs_idx);
    end
  endtask

  task automatic test_star();
    bit em;
    int ei;
`ifdef SME_STAR_EN
    em = 1'b1; ei = 1;
`else
    em = 1'b0; ei = 0;
`endif
    load("abcdef", "b*e");
    run(1'b1);
    checks++;
    if (!obs_valid || obs_match !== em || obs_idx != ei) begin
      failures++;
      $display("FAIL star: valid=%b match=%b idx=%0d, want 1 %b %0d", obs_valid, obs_match, obs_idx, em, ei);
    end
  endtask

  task automatic test_overflow();
    string s, p;
    s = "";
    for (int i = 0; i < 40; i++) s = {s, "a"};
    for (int i = 0; i < 40; i++) s.putc(i, 8'(8'h30 + i));
    p = "a";
    p.putc(0, 8'(8'h30 + 35));
    load(s, p);
    run(1'b1);
    checks++;
    if (!obs_valid || obs_match !== 1'b0 || obs_idx != 0) begin
      failures++;
      $display("FAIL overflow_dropped: valid=%b match=%b idx=%0d, want 1 0 0", obs_valid, obs_match, obs_idx);
    end
    p.putc(0, 8'(8'h30 + 31));
    load("", p);
    run(1'b1);
    checks++;
    if (!obs_valid || obs_match !== 1'b1 || obs_idx != 31) begin
      failures++;
      $display("FAIL overflow_last: valid=%b match=%b idx=%0d, want 1 1 31", obs_valid, obs_match, obs_idx);
    end
  endtask

  task automatic test_back_to_back();
    load("abc", "b");
    run(1'b0);
    checks++;
    if (!obs_valid || obs_match !== 1'b1 || obs_idx != 1) begin
      failures++;
      $display("FAIL b2b_first: valid=%b match=%b idx=%0d, want 1 1 1", obs_valid, obs_match, obs_idx);
    end
    load("hello world", "o w");
    run(1'b1);
    checks++;
    if (!obs_valid || obs_match !== 1'b1 || obs_idx != 4) begin
      failures++;
      $display("FAIL b2b_second: valid=%b match=%b idx=%0d, want 1 1 4", obs_valid, obs_match, obs_idx);
    end
  endtask

  task automatic test_reset_mid_search();
    string s;
    int nvalid;
    s = "";
    for (int i = 0; i < STR_DEPTH; i++) s = {s, "a"};
    load(s, "aaaaaaab");
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_str = "";
    nvalid = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      failures++;
      $display("FAIL abort_no_valid: pulses=%0d, want 0", nvalid);
    end
    checks++;
    if (match !== 1'b0 || match_index !== '0) begin
      failures++;
      $display("FAIL abort_outputs: match=%b idx=%0d, want 0 0", match, match_index);
    end
    load("abc", "c$");
    run(1'b1);
    checks++;
    if (!obs_valid || obs_match !== 1'b1 || obs_idx != 2) begin
      failures++;
      $display("FAIL after_abort: valid=%b match=%b idx=%0d, want 1 1 2", obs_valid, obs_match, obs_idx);
    end
  endtask

  task automatic test_random();
    byte sa[4] = '{8'h61, 8'h62, 8'h20, 8'h63};
    byte pa[6] = '{8'h61, 8'h62, 8'h2E, 8'h5E, 8'h24, 8'h20};
    for (int it = 0; it < 30; it++) begin
      string s, p;
      int n, k, kmax, ei;
      bit em, reuse;
      reuse = (it > 0) && ($urandom_range(0, 3) == 0);
      s = "";
      if (!reuse) begin
        n = int'($urandom_range(1, 36));
        for (int i = 0; i < n; i++) s = {s, "a"};
        for (int i = 0; i < n; i++) s.putc(i, sa[$urandom_range(0, 3)]);
      end
      n = reuse ? model_str.len() : ((s.len() > STR_DEPTH) ? STR_DEPTH : s.len());
      kmax = (n < PAT_DEPTH) ? n : PAT_DEPTH;
      k = int'($urandom_range(1, kmax));
      p = "";
      for (int i = 0; i < k; i++) p = {p, "a"};
      for (int i = 0; i < k; i++) p.putc(i, pa[$urandom_range(0, 5)]);
      load(s, p);
      ref_search(model_str, p, em, ei);
      run(1'b1);
      checks++;
      if (!obs_valid || obs_match !== em || obs_idx != ei) begin
        failures++;
        $display("FAIL rand_%0d str=\"%s\" pat=\"%s\": valid=%b match=%b idx=%0d, want 1 %b %0d",
                 it, model_str, p, obs_valid, obs_match, obs_idx, em, ei);
      end
      checks++;
      if (!obs_valid || obs_cyc > n * (k + 1) + 2 || obs_tail) begin
        failures++;
        $display("FAIL rand_latency_%0d: cycles=%0d extra_valid=%b, want <=%0d and 0",
                 it, obs_cyc, obs_tail, n * (k + 1) + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_abc();
    test_star();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid_search();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
